// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the MEM-stage size-control encodings, the controller state type,
// address field widths and helpers that turn a size code into a byte count.
package data_cache_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 17 - OFFSET_W - INDEX_W;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cache_state_t;

  // Bytes touched by a load; 0 marks an undefined size code.
  function automatic logic [2:0] load_bytes(input logic [2:0] sz);
    case (sz)
      SZ_B, SZ_BU: load_bytes = 3'd1;
      SZ_H, SZ_HU: load_bytes = 3'd2;
      SZ_W:        load_bytes = 3'd4;
      default:     load_bytes = 3'd0;
    endcase
  endfunction

  // Bytes written by a store; unsigned codes are not valid store sizes.
  function automatic logic [2:0] store_bytes(input logic [2:0] sz);
    case (sz)
      SZ_B:    store_bytes = 3'd1;
      SZ_H:    store_bytes = 3'd2;
      SZ_W:    store_bytes = 3'd4;
      default: store_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: selects a byte, half or word from a cache
// line at a byte offset and sign/zero-extends it per the size code.
// Ports:
//   line_i   : full line, little-endian (byte 0 in bits [7:0])
//   offset_i : byte offset of the access within the line
//   size_i   : size control (b, h, w, bu, hu); other codes yield 0
//   data_o   : extended load data
module load_extend
  import data_cache_pkg::*;
#(
  parameter int LINE_BITS  = 128,
  parameter int DATA_WIDTH = 32
) (
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic [OFFSET_W-1:0]   offset_i,
  input  logic [2:0]            size_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] win;

  always_comb begin
    // Shift the addressed byte down to bit 0; callers guarantee the access
    // does not run past the end of the line.
    win = DATA_WIDTH'(line_i >> {offset_i, 3'b000});
    case (size_i)
      SZ_B:    data_o = {{(DATA_WIDTH-8){win[7]}}, win[7:0]};
      SZ_H:    data_o = {{(DATA_WIDTH-16){win[15]}}, win[15:0]};
      SZ_W:    data_o = win;
      SZ_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, win[7:0]};
      SZ_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, win[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the MEM stage and a byte-addressable data memory with combinational reads.
// Load hits answer in the same cycle; a load miss stalls while the 16-byte
// line is refilled one word per cycle. Stores always write through.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   CpuRead/CpuWrite  : load / store request from the pipeline
//   CpuSizeCtr        : access size code (b, h, w, bu, hu)
//   CpuAddr           : byte address
//   CpuWriteData      : store data, low-aligned
//   CpuReadData       : extended load data
//   Stall             : holds the pipeline during a refill
//   MemAddr/MemSizeCtr/MemWriteData/MemWrite : data memory request
//   MemReadData       : data memory read data (combinational)
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CpuRead,
  input  logic                  CpuWrite,
  input  logic [2:0]            CpuSizeCtr,
  input  logic [ADDR_WIDTH-1:0] CpuAddr,
  input  logic [DATA_WIDTH-1:0] CpuWriteData,
  output logic [DATA_WIDTH-1:0] CpuReadData,
  output logic                  Stall,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [2:0]            MemSizeCtr,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  localparam int LINE_BITS  = LINE_WORDS * DATA_WIDTH;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam int BASE_W     = ADDR_WIDTH - OFFSET_W;

  // Address fields of the current request
  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index, index_nx;
  logic [TAG_BITS-1:0] tag;

  assign offset   = CpuAddr[OFFSET_W-1:0];
  assign index    = CpuAddr[OFFSET_W +: INDEX_W];
  assign tag      = CpuAddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign index_nx = index + INDEX_W'(1);

  // Storage: valid bits are control state; tags and data need no reset
  logic [SETS-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  cache_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [INDEX_W-1:0]  base_idx;

  assign base_idx = base_q[INDEX_W-1:0];

  logic                  hit;
  logic [2:0]            ld_bytes, st_bytes;
  logic                  ld_cross, st_cross;
  logic [DATA_WIDTH-1:0] ext_data;

  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign ld_bytes = load_bytes(CpuSizeCtr);
  assign st_bytes = store_bytes(CpuSizeCtr);
  // An access crosses the line when offset + size runs past the last byte.
  assign ld_cross = ({1'b0, offset} + {{(OFFSET_W-2){1'b0}}, ld_bytes})
                    > (OFFSET_W+1)'(LINE_BYTES);
  assign st_cross = ({1'b0, offset} + {{(OFFSET_W-2){1'b0}}, st_bytes})
                    > (OFFSET_W+1)'(LINE_BYTES);

  load_extend #(
    .LINE_BITS (LINE_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .line_i  (data_q[index]),
    .offset_i(offset),
    .size_i  (CpuSizeCtr),
    .data_o  (ext_data)
  );

  // Store merge: byte-enable mask and store data aligned to the line offset
  logic [3:0]            st_mask4;
  logic [LINE_BYTES-1:0] st_bmask;
  logic [LINE_BITS-1:0]  st_mask, st_line;

  always_comb begin
    case (st_bytes)
      3'd1:    st_mask4 = 4'b0001;
      3'd2:    st_mask4 = 4'b0011;
      3'd4:    st_mask4 = 4'b1111;
      default: st_mask4 = 4'b0000;
    endcase
    st_bmask = LINE_BYTES'(st_mask4) << offset;
    st_mask  = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      st_mask[8*b +: 8] = {8{st_bmask[b]}};
    end
    st_line = LINE_BITS'(CpuWriteData) << {offset, 3'b000};
  end

  // Controller: next state, memory port steering and CPU responses
  logic fill_we, tag_we, st_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    valid_d      = valid_q;
    Stall        = 1'b0;
    MemAddr      = CpuAddr;
    MemSizeCtr   = CpuSizeCtr;
    MemWriteData = CpuWriteData;
    MemWrite     = 1'b0;
    CpuReadData  = '0;
    fill_we      = 1'b0;
    tag_we       = 1'b0;
    st_we        = 1'b0;

    case (state_q)
      IDLE: begin
        // A store wins if both request lines are raised.
        if (CpuWrite) begin
          if (st_bytes != 3'd0) begin
            MemWrite = 1'b1;
            if (st_cross) begin
              // Partial line updates are not tracked across two lines;
              // drop both so the next load refetches from memory.
              valid_d[index]    = 1'b0;
              valid_d[index_nx] = 1'b0;
            end else if (hit) begin
              st_we = 1'b1;
            end
          end
        end else if (CpuRead && (ld_bytes != 3'd0)) begin
          if (ld_cross) begin
            CpuReadData = MemReadData;
          end else if (hit) begin
            CpuReadData = ext_data;
          end else begin
            // The line is invalidated for the duration of the refill so a
            // half-written line can never be seen as a hit.
            Stall          = 1'b1;
            valid_d[index] = 1'b0;
            base_d         = CpuAddr[ADDR_WIDTH-1:OFFSET_W];
            cnt_d          = '0;
            state_d        = REFILL;
          end
        end
      end
      REFILL: begin
        Stall      = 1'b1;
        MemAddr    = {base_q, cnt_q, 2'b00};
        MemSizeCtr = SZ_W;
        fill_we    = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LINE_WORDS-1)) begin
          valid_d[base_idx] = 1'b1;
          tag_we            = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      Stall       = 1'b0;
      MemWrite    = 1'b0;
      CpuReadData = '0;
      st_we       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    if (fill_we) begin
      data_q[base_idx][int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= MemReadData;
    end
    if (tag_we) begin
      tag_q[base_idx] <= base_q[BASE_W-1 -: TAG_BITS];
    end
    if (st_we) begin
      data_q[index] <= (data_q[index] & ~st_mask) | (st_line & st_mask);
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  import data_cache_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, CpuRead, CpuWrite, Stall, MemWrite;
  logic [2:0]  CpuSizeCtr, MemSizeCtr;
  logic [16:0] CpuAddr, MemAddr;
  logic [31:0] CpuWriteData, CpuReadData, MemWriteData, MemReadData;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .CpuRead(CpuRead), .CpuWrite(CpuWrite),
    .CpuSizeCtr(CpuSizeCtr), .CpuAddr(CpuAddr), .CpuWriteData(CpuWriteData),
    .CpuReadData(CpuReadData), .Stall(Stall), .MemAddr(MemAddr),
    .MemSizeCtr(MemSizeCtr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemReadData(MemReadData)
  );

  // Data memory seen by the DUT, plus an independent reference image
  bit [7:0]    mem     [0:131071];
  bit [7:0]    ref_mem [0:131071];
  logic        pre_we;
  logic [16:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++) mem[pre_addr + 17'(i)] <= pre_data[8*i +: 8];
    end else if (MemWrite) begin
      case (MemSizeCtr)
        3'b000: mem[MemAddr] <= MemWriteData[7:0];
        3'b001: for (int i = 0; i < 2; i++) mem[MemAddr + 17'(i)] <= MemWriteData[8*i +: 8];
        3'b010: for (int i = 0; i < 4; i++) mem[MemAddr + 17'(i)] <= MemWriteData[8*i +: 8];
        default: ;
      endcase
    end
  end

  logic [16:0] ra1, ra2, ra3;
  logic [31:0] rword;
  always_comb begin
    ra1 = MemAddr + 17'd1;
    ra2 = MemAddr + 17'd2;
    ra3 = MemAddr + 17'd3;
    rword = {mem[ra3], mem[ra2], mem[ra1], mem[MemAddr]};
    case (MemSizeCtr)
      3'b000:  MemReadData = {{24{rword[7]}}, rword[7:0]};
      3'b001:  MemReadData = {{16{rword[15]}}, rword[15:0]};
      3'b010:  MemReadData = rword;
      3'b100:  MemReadData = {24'd0, rword[7:0]};
      3'b101:  MemReadData = {16'd0, rword[15:0]};
      default: MemReadData = 32'd0;
    endcase
  end

  always @(posedge clk)
    assert (!(rst_n && CpuRead && CpuWrite)) else $error("illegal request: read and write together");

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] seen_addr [8];
  int          res_tag [64];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [16:0] a, input logic [2:0] sz);
    logic [31:0] w;
    w = {ref_mem[a + 17'd3], ref_mem[a + 17'd2], ref_mem[a + 17'd1], ref_mem[a]};
    case (sz)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic preload(input logic [16:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[a + 17'(i)] = w[8*i +: 8];
    pre_we = 1'b1; pre_addr = a; pre_data = w;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] sz, input logic [16:0] a,
                         input logic [31:0] exp_d, input int exp_st, input string nm);
    int st;
    bit done;
    st = 0; done = 1'b0;
    CpuRead = 1'b1; CpuWrite = 1'b0; CpuSizeCtr = sz; CpuAddr = a;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1'b1;
        break;
      end
      if (st < 8) seen_addr[st] = MemAddr;
      st++;
      @(posedge clk); #1;
    end
    check({nm, " stall cycles"}, 32'(st), 32'(exp_st));
    if (done) check({nm, " data"}, CpuReadData, exp_d);
    else begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: Stall still high after 16 cycles", nm);
    end
    @(posedge clk); #1;
    CpuRead = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] sz, input logic [16:0] a,
                          input logic [31:0] wd, input bit exp_mw, input string nm);
    CpuWrite = 1'b1; CpuRead = 1'b0; CpuSizeCtr = sz; CpuAddr = a; CpuWriteData = wd;
    @(negedge clk);
    check({nm, " MemWrite"}, 32'(MemWrite), 32'(exp_mw));
    check({nm, " Stall"}, 32'(Stall), 32'd0);
    if (exp_mw) begin
      check({nm, " MemAddr"}, 32'(MemAddr), 32'(a));
      check({nm, " MemSizeCtr"}, 32'(MemSizeCtr), 32'(sz));
      check({nm, " MemWriteData"}, MemWriteData, wd);
      for (int k = 0; k < nbytes_of(sz); k++) ref_mem[a + 17'(k)] = wd[8*k +: 8];
    end
    @(posedge clk); #1;
    CpuWrite = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; CpuRead = 1'b0; CpuWrite = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) res_tag[i] = -1;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  sz;
    logic [16:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    int          exp_st;
    bit          exp_mw;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [2:0] ld_sizes [5];
    logic [2:0] st_sizes [8];
    bit found;

    vt[0]  = '{1'b0, SZ_B,   17'h00107, 32'h0,        32'hFFFFFF80, 0, 1'b0};
    vt[1]  = '{1'b0, SZ_BU,  17'h00107, 32'h0,        32'h00000080, 0, 1'b0};
    vt[2]  = '{1'b0, SZ_HU,  17'h00106, 32'h0,        32'h000080FF, 0, 1'b0};
    vt[3]  = '{1'b0, SZ_H,   17'h00104, 32'h0,        32'h00002222, 0, 1'b0};
    vt[4]  = '{1'b1, SZ_H,   17'h00108, 32'h0000ABCD, 32'h0,        0, 1'b1};
    vt[5]  = '{1'b0, SZ_W,   17'h00108, 32'h0,        32'h3333ABCD, 0, 1'b0};
    vt[6]  = '{1'b0, SZ_W,   17'h02104, 32'h0,        32'h55667788, 5, 1'b0};
    vt[7]  = '{1'b0, SZ_W,   17'h00104, 32'h0,        32'h80FF2222, 5, 1'b0};
    vt[8]  = '{1'b0, 3'b011, 17'h0010C, 32'h0,        32'h00000000, 0, 1'b0};
    vt[9]  = '{1'b0, SZ_W,   17'h0010E, 32'h0,        32'h77664444, 0, 1'b0};
    vt[10] = '{1'b1, SZ_BU,  17'h00104, 32'h000000EE, 32'h0,        0, 1'b0};
    vt[11] = '{1'b0, SZ_W,   17'h00104, 32'h0,        32'h80FF2222, 0, 1'b0};
    vt[12] = '{1'b1, SZ_W,   17'h0010E, 32'hDEADBEEF, 32'h0,        0, 1'b1};
    vt[13] = '{1'b0, SZ_W,   17'h0010C, 32'h0,        32'hBEEF4444, 5, 1'b0};
    vt[14] = '{1'b0, SZ_W,   17'h00110, 32'h0,        32'h9988DEAD, 5, 1'b0};
    vt[15] = '{1'b0, SZ_W,   17'h0010C, 32'h0,        32'hBEEF4444, 0, 1'b0};

    ld_sizes = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
    st_sizes = '{SZ_B, SZ_H, SZ_W, SZ_B, SZ_H, SZ_W, 3'b011, SZ_BU};

    rst_n = 1'b0; CpuRead = 1'b0; CpuWrite = 1'b0; CpuSizeCtr = SZ_W;
    CpuAddr = '0; CpuWriteData = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(posedge clk); #1;
    preload(17'h00100, 32'h11111111);
    preload(17'h00104, 32'h80FF2222);
    preload(17'h00108, 32'h33333333);
    preload(17'h0010C, 32'h44444444);
    preload(17'h00110, 32'h99887766);
    preload(17'h02104, 32'h55667788);

    // Reset state with a pending load: outputs held quiet
    CpuRead = 1'b1; CpuAddr = 17'h00104;
    @(negedge clk);
    check("reset Stall", 32'(Stall), 32'd0);
    check("reset MemWrite", 32'(MemWrite), 32'd0);
    check("reset CpuReadData", CpuReadData, 32'd0);
    CpuRead = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    // First load misses and refills the line word by word
    do_load(SZ_W, 17'h00104, 32'h80FF2222, 5, "refill lw 0x104");
    for (int i = 1; i <= 4; i++)
      check($sformatf("refill MemAddr word %0d", i - 1), 32'(seen_addr[i]),
            32'h100 + 32'(4 * (i - 1)));

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) do_store(vt[i].sz, vt[i].addr, vt[i].wd, vt[i].exp_mw, $sformatf("vec%0d st", i));
      else do_load(vt[i].sz, vt[i].addr, vt[i].exp_d, vt[i].exp_st, $sformatf("vec%0d ld", i));
    end

    // Reset arriving while refill word 2 is on the memory port
    CpuRead = 1'b1; CpuSizeCtr = SZ_W; CpuAddr = 17'h02104;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (Stall && MemAddr == 17'h02108) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("abort reached word 2", 32'(found), 32'd1);
    rst_n = 1'b0; CpuRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort Stall after reset", 32'(Stall), 32'd0);
    @(posedge clk); #1;
    do_load(SZ_W, 17'h00104, 32'h80FF2222, 5, "post-abort lw 0x104");
    do_load(SZ_W, 17'h02104, 32'h55667788, 5, "post-abort lw 0x2104");
    do_load(SZ_W, 17'h02104, 32'h55667788, 0, "post-abort hit 0x2104");

    // Random traffic against the transaction-level model
    do_reset(2);
    for (int n = 0; n < 300; n++) begin
      int tg, ix, off, nb;
      logic [16:0] a;
      logic [2:0] sz;
      logic [31:0] wd;
      tg  = int'($urandom_range(0, 3));
      ix  = int'($urandom_range(0, 7));
      off = int'($urandom_range(0, 15));
      a   = 17'((tg << 10) | (ix << 4) | off);
      if ($urandom_range(0, 1) == 1) begin
        int exp_st;
        sz = ld_sizes[$urandom_range(0, 4)];
        nb = nbytes_of(sz);
        exp_st = 0;
        if (off + nb <= 16) begin
          if (res_tag[ix] != tg) exp_st = 5;
          res_tag[ix] = tg;
        end
        do_load(sz, a, ref_load(a, sz), exp_st, $sformatf("rand%0d ld @%05h sz%0d", n, a, sz));
      end else begin
        sz = st_sizes[$urandom_range(0, 7)];
        wd = $urandom;
        nb = (sz <= 3'b010) ? nbytes_of(sz) : 0;
        do_store(sz, a, wd, nb != 0, $sformatf("rand%0d st @%05h sz%0d", n, a, sz));
        if (nb != 0 && off + nb > 16) begin
          res_tag[ix] = -1;
          res_tag[(ix + 1) % 64] = -1;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM-stage address/size/data signals and the byte-addressable data memory.
- Load hits return data combinationally in the same cycle. Load misses stall the pipeline while a 16-byte line is refilled over four word reads.
- Stores always write through to memory in the same cycle. Store hits also update the cached line.

Parameters:
- ADDR_WIDTH, 17, byte address width; matches the 2^17-byte data memory.
- DATA_WIDTH, 32, word width.
- SETS, 64, number of lines; index = Addr[9:4].
- LINE_WORDS, 4, words per line; offset = Addr[3:0]; tag = Addr[ADDR_WIDTH-1:10].

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: synchronous, active-low reset.
- CpuRead in 1: load request.
- CpuWrite in 1: store request.
- CpuSizeCtr in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- CpuAddr in ADDR_WIDTH: byte address.
- CpuWriteData in DATA_WIDTH: store data, low-aligned.
- CpuReadData out DATA_WIDTH: extended load data.
- Stall out 1: pipeline hold.
- MemAddr out ADDR_WIDTH: memory address (drives the data memory's ALUResult).
- MemSizeCtr out 3: memory size control.
- MemWriteData out DATA_WIDTH: memory write data.
- MemWrite out 1: memory write enable.
- MemReadData in DATA_WIDTH: combinational memory read data.

Behaviour:
- Storage:
  - Tags and valid bits are held in flops.
  - Data is SETS x 16 bytes, little-endian.
  - Hit = valid[index] && tag match.
- Reset:
  - While rst_n is low at a clk edge: all valid bits clear, state = IDLE.
  - Outputs: Stall=0, MemWrite=0, CpuReadData=0.
- FSM states are IDLE and REFILL, with a 2-bit word counter.
- IDLE, load hit:
  - CpuReadData = selected bytes extended per CpuSizeCtr: b/h sign-extend, bu/hu zero-extend, w raw.
  - Undefined size codes return 0.
  - Stall=0.
- IDLE, load miss:
  - Stall=1 this cycle; latch the line base {tag, index, 4'b0}.
  - Move to REFILL, counter=0.
- REFILL:
  - Stall=1.
  - MemAddr = base + 4*counter, MemSizeCtr=010, MemWrite=0.
  - At each edge, capture MemReadData into word[counter] and increment the counter.
  - After word 3, set valid and tag, return to IDLE.
  - Total Stall is 5 cycles; the load completes as a hit in the 6th cycle.
- IDLE, store:
  - Drive MemWrite=1 and pass MemAddr/MemSizeCtr/MemWriteData from the CPU inputs.
  - Stall=0; memory commits at the edge.
  - Hit: merge 1/2/4 bytes into the line at the same edge.
  - Miss: cache unchanged.
  - Size codes other than 000/001/010: MemWrite=0 and no update.
- Line-crossing accesses (offset + size > 16):
  - Loads bypass the cache: MemAddr/MemSizeCtr from the CPU, CpuReadData = MemReadData, no stall.
  - Stores write through and clear valid at index and index+1 (mod SETS).
- Idle ports: in IDLE with no request, MemAddr = CpuAddr, MemSizeCtr = CpuSizeCtr, MemWrite=0.
- CpuRead && CpuWrite together is illegal. Bench assertion; the store takes priority.
- CPU inputs must be held stable while Stall=1. Requests are ignored during REFILL.
- Reset during REFILL aborts the refill: the line stays invalid and the next cycle is IDLE with Stall=0.
- No address wrap: refill addresses are always inside one aligned line.

Decomposition:
- Package data_cache_pkg holds:
  - SizeCtr encoding constants SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - State enum cache_state_t {IDLE, REFILL}.
  - OFFSET_W=4, INDEX_W=6, TAG_W localparams.
- One sub-module, load_extend: combinational byte/half select plus sign/zero extension from a 16-byte line and offset. It is reusable for the bypass path.

Test Plan:
- Reset: rst_n low for 2 cycles -> Stall=0, MemWrite=0; first lw 0x104 misses (Stall=1).
- Refill:
  - Setup: memory 0x100..0x10C = 0x11111111, 0x80FF2222, 0x33333333, 0x44444444.
  - Stimulus: lw 0x104.
  - Required: Stall high 5 cycles; MemAddr = 0x100, 0x104, 0x108, 0x10C in cycles 1-4; then CpuReadData = 0x80FF2222, Stall=0.
- Extension on hit, zero stall:
  - lb 0x107 -> 0xFFFFFF80.
  - lbu 0x107 -> 0x00000080.
  - lhu 0x106 -> 0x000080FF.
  - lh 0x104 -> 0x00002222.
- Store hit: sh 0xABCD @0x108 -> MemWrite=1, MemSizeCtr=001, Stall=0; next lw 0x108 -> 0x3333ABCD with no stall.
- Conflict: lw 0x2104 (same index 0x10) -> refill from 0x2100; then lw 0x104 misses again with a 5-cycle stall.
- Reset mid-refill: rst_n low during refill word 2 -> next cycle Stall=0; lw 0x104 misses again and refills correctly.
